// File: rtl/piso_pkg.sv
// Shared sizing for the PE-array serial unloader.
// Lane = one complex re/im pair.
package piso_pkg;

    localparam int PE_NUM_DEF     = 8;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int LANE_W_DEF     = 2 * DATA_WIDTH_DEF;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-deep holding register for the next parallel word.
// Writer only loads when empty; reader takes when shifter frees up.
module piso_hold_reg #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (take) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/piso.sv
// Parallel-in/serial-out unloader: one lane per clock, lane 0 first.
// A held word follows the current one with no bubble.
module piso
    import piso_pkg::*;
#(
    parameter int PE_NUM     = PE_NUM_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PE_NUM*DATA_WIDTH*2-1:0] p_in,
    input  logic                           load,
    output logic                           ready,
    output logic [DATA_WIDTH*2-1:0]        s_out,
    output logic                           valid_out,
    output logic                           last_out,
    output logic                           drop
);

    localparam int LANE_W = 2 * DATA_WIDTH;
    localparam int WORD_W = PE_NUM * LANE_W;
    localparam int CNT_W  = cnt_w(PE_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PE_NUM - 1);

    logic [WORD_W-1:0] sr;
    logic [CNT_W-1:0]  cnt;
    logic              active;

    logic [WORD_W-1:0] hold_q;
    logic              hold_v;

    logic              at_last;
    logic              free;
    logic              accept;
    logic              start_hold;
    logic              start_p;
    logic              start;
    logic              hold_load;
    logic [WORD_W-1:0] start_word;

    assign ready = !hold_v;

    always_comb begin
        at_last    = active && (cnt == CNT_LAST);
        free       = !active || at_last;
        accept     = load && ready;
        start_hold = free && hold_v;
        start_p    = free && !hold_v && accept;
        start      = start_hold || start_p;
        // hold can only be written while empty, so it never collides with take
        hold_load  = accept && !free;
        start_word = start_hold ? hold_q : p_in;
    end

    piso_hold_reg #(
        .W (WORD_W)
    ) u_hold (
        .clk   (clk),
        .clear (rst),
        .load  (hold_load),
        .take  (start_hold),
        .d     (p_in),
        .q     (hold_q),
        .valid (hold_v)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            active    <= 1'b0;
            s_out     <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            drop <= load && !ready;
            if (start) begin
                s_out     <= start_word[LANE_W-1:0];
                sr        <= start_word >> LANE_W;
                cnt       <= '0;
                active    <= 1'b1;
                valid_out <= 1'b1;
                last_out  <= (PE_NUM == 1);
            end else if (!free) begin
                s_out     <= sr[LANE_W-1:0];
                sr        <= sr >> LANE_W;
                cnt       <= cnt + 1'b1;
                valid_out <= 1'b1;
                last_out  <= ((cnt + 1'b1) == CNT_LAST);
            end else begin
                active    <= 1'b0;
                valid_out <= 1'b0;
                last_out  <= 1'b0;
                s_out     <= '0;
            end
        end
    end

endmodule
